// File: rtl/uart_tx_buffer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer_if
//   Character push bus feeding uart_tx_buffer.
//
//   Handshake: char_valid is a single-cycle strobe and char_in is sampled on the
//   rising clk edge where char_valid=1. There is no ready signal. The consumer
//   accepts every strobe it has room for. When it has no room, it drops the byte
//   and reports the drop on its fifo_full / overflow status outputs.
//
//   Signals:
//     char_in    [7:0]  byte to transmit
//     char_valid        push strobe
//   Modports:
//     master  producer side (drives char_in / char_valid)
//     slave   uart_tx_buffer side
// -----------------------------------------------------------------------------
interface uart_tx_buffer_if;
  logic [7:0] char_in;
  logic       char_valid;

  modport master (output char_in, output char_valid);
  modport slave  (input char_in, input char_valid);
endinterface

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//   Buffers strobed characters in a small synchronous FIFO and serialises them
//   onto an asynchronous TX line. The default frame is 8N1 and lasts
//   10*CLK_DIV cycles.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit is inserted between the data bits and
//     the stop bit, which makes the frame 11*CLK_DIV cycles.
//
//   Ports:
//     clk        system clock, rising edge
//     rstn       asynchronous active-low reset; aborts any frame in flight
//     push_if    character push bus (slave modport)
//     tx         serial line, idles high
//     busy       frame in progress or FIFO non-empty
//     fifo_full  FIFO holds FIFO_DEPTH entries
//     overflow   sticky drop flag, cleared only by reset
//     level      FIFO occupancy, 0..FIFO_DEPTH
//     dbg_state  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic               clk,
  input  logic               rstn,
  uart_tx_buffer_if.slave    push_if,
  output logic               tx,
  output logic               busy,
  output logic               fifo_full,
  output logic               overflow,
  output logic [PTR_W:0]     level,
  output logic [2:0]         dbg_state
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   level_q;
  logic             overflow_q;

  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [DIV_W-1:0] div_q;
  logic             tx_q;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic pop, push, div_last, tx_d;

  assign div_last  = (div_q == DIV_LAST);
  assign fifo_full = (level_q == LVL_FULL);
  // A same-cycle pop frees a slot, so a push into a full FIFO still succeeds.
  assign push      = push_if.char_valid && (!fifo_full || pop);

  assign tx        = tx_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE) || (level_q != '0);
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed: contents are only read when level != 0)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= push_if.char_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (push_if.char_valid && !push) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, pop request and the line level for the current state.
  // tx is registered from tx_d, so the line lags the state by one cycle.
  // That lag produces the two-edge push-to-start-bit latency.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (div_last) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (div_last && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (div_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (div_last) begin
          // Chain straight into the next frame when more data is waiting.
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register, bit index, divider and line register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (pop) begin
        shift_q   <= mem[rptr_q];
        bit_idx_q <= '0;
        div_q     <= '0;
`ifdef UART_TX_PARITY_EN
        par_q     <= ^mem[rptr_q];
`endif
      end else if (state_q == S_IDLE) begin
        div_q <= '0;
      end else begin
        div_q <= div_last ? '0 : div_q + 1'b1;
        if ((state_q == S_DATA) && div_last) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffer
//   Directed bench for uart_tx_buffer (CLK_DIV=4, FIFO_DEPTH=16). Bytes are
//   pushed into exp_q as they are driven. A line receiver decodes tx frames
//   and compares each one against the head of exp_q.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffer;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic          clk;
  logic          rstn;
  logic          tx, busy, fifo_full, overflow;
  logic [PW:0]   level;
  logic [2:0]    dbg_state;

  uart_tx_buffer_if push_if ();

  uart_tx_buffer #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH),
    .PTR_W      (PW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .push_if   (push_if),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .level     (level),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // ---------------- line receiver ----------------
  // Detects the start bit on the first falling-edge sample where tx=0 (offset 0)
  // and then samples each bit in the middle of its period.
  logic       rx_active;
  int         rx_cnt;
  int         slot;
  logic [7:0] rx_byte;
  logic       rx_par;
  logic [7:0] e_byte;

  initial begin
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_byte   = '0;
    rx_par    = 1'b0;
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_byte   = '0;
          start_q.push_back(cyc);
        end
      end else begin
        rx_cnt++;
        if ((rx_cnt % DIV) == (DIV / 2)) begin
          slot = rx_cnt / DIV;
          if (slot == 0) begin
            check("start_bit", {31'd0, tx}, 32'd0);
          end else if (slot <= 8) begin
            rx_byte[slot-1] = tx;
          end else if (slot == NBITS - 1) begin
            check("stop_bit", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
              e_byte = exp_q.pop_front();
              check("rx_byte", {24'd0, rx_byte}, {24'd0, e_byte});
`ifdef UART_TX_PARITY_EN
              check("parity_bit", {31'd0, rx_par}, {31'd0, ^e_byte});
`endif
            end
            rx_active = 1'b0;
          end else begin
            rx_par = tx;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, input bit expect_tx);
    @(negedge clk);
    push_if.char_in    = b;
    push_if.char_valid = 1'b1;
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic end_push();
    @(negedge clk);
    push_if.char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy && (exp_q.size() == 0) && !rx_active) break;
    end
    check("idle_timeout", {31'd0, (k < limit)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn               = 1'b0;
    push_if.char_in    = '0;
    push_if.char_valid = 1'b0;

    // Reset and quiet idle
    repeat (4) @(negedge clk);
    check("rst_hold", {27'd0, tx, busy, fifo_full, overflow, level != 0}, {27'd0, 5'b10000});
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("rst_idle", {22'd0, tx, busy, overflow, fifo_full, level}, {22'd0, 4'b1000, 5'd0});
    end

    // Single byte 0x55: latency and frame length
    push_byte(8'h55, 1'b1);
    end_push();                                   // after push edge N
    check("lat_level", {27'd0, level}, 32'd1);
    check("lat_tx_n0", {31'd0, tx}, 32'd1);
    @(negedge clk);                               // after N+1
    check("lat_tx_n1", {31'd0, tx}, 32'd1);
    check("lat_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);                               // after N+2
    check("lat_tx_n2", {31'd0, tx}, 32'd0);
    repeat (FRAME - 2) @(negedge clk);            // after N+FRAME
    check("busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);                               // after N+FRAME+1
    check("busy_drop", {31'd0, busy}, 32'd0);
    wait_idle(200);

    // Burst of three: back-to-back frames, order preserved
    start_q.delete();
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    end_push();
    check("burst_level", {27'd0, level}, 32'd2);
    wait_idle(400);
    check("burst_frames", start_q.size(), 32'd3);
    if (start_q.size() == 3) begin
      check("burst_gap01", start_q[1] - start_q[0], FRAME);
      check("burst_gap12", start_q[2] - start_q[1], FRAME);
    end

    // Overflow: 20 pushes, 17 survive (one popped during the burst)
    start_q.delete();
    for (int i = 0; i < 20; i++) begin
      push_byte(i[7:0], i < 17);
      if (i == 17) begin
        check("ovf_full_before", {31'd0, fifo_full}, 32'd1);
        check("ovf_not_yet", {31'd0, overflow}, 32'd0);
      end
    end
    end_push();
    check("ovf_level", {27'd0, level}, DEPTH);
    check("ovf_full", {31'd0, fifo_full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    wait_idle(17 * FRAME + 200);
    check("ovf_frames", start_q.size(), 32'd17);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_level_end", {27'd0, level}, 32'd0);

    // Reset during data bit 3 of 0xA5
    push_byte(8'hA5, 1'b0);
    end_push();                                   // after push edge N
    repeat (19) @(negedge clk);                   // inside data bit 3
    check("mid_state", {29'd0, dbg_state}, 32'd2);
    check("mid_tx_bit3", {31'd0, tx}, 32'd0);     // bit 3 of 0xA5 is 0
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_level", {27'd0, level}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    push_byte(8'h3C, 1'b1);
    end_push();
    wait_idle(200);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 -> 1, 0x03 -> 0 (checked by the receiver)
    push_byte(8'h07, 1'b1);
    end_push();
    wait_idle(200);
    check("par_07", {31'd0, rx_par}, 32'd1);
    push_byte(8'h03, 1'b1);
    end_push();
    wait_idle(200);
    check("par_03", {31'd0, rx_par}, 32'd0);
`endif

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Downstream consumer of the memory model's simulated-UART byte strobe (sim_uart_char_out / sim_uart_char_valid). It buffers strobed characters in a small FIFO and serialises them onto a standard 8N1 asynchronous TX line at a fixed clock divider. This lets the same store-to-UART path drive a real board pin, alongside the simulator's console print.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; legal range >= 2.
FIFO_DEPTH, 16, character slots; power of two, >= 2.
PTR_W, 4, log2(FIFO_DEPTH); width of the FIFO pointers.

Ports:
clk  in  1  system clock; all state updates on posedge.
rstn  in  1  asynchronous, active-low reset.
char_in  in  8  byte to transmit; sampled only when char_valid=1.
char_valid  in  1  single-cycle push strobe, driven by sim_uart_char_valid.
tx  out  1  serial line; idles high.
busy  out  1  high while a frame is in progress or the FIFO is non-empty.
fifo_full  out  1  high when the FIFO holds FIFO_DEPTH entries.
overflow  out  1  sticky; set when a push is dropped; cleared only by reset.
level  out  PTR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rstn=0, asynchronous): tx=1, busy=0, fifo_full=0, overflow=0, level=0. Pointers, bit counter and divider counter go to 0; FSM goes to IDLE. Asserting reset mid-frame aborts the frame immediately: tx returns high, FIFO contents are discarded.
- FIFO push: char_valid=1 and (level<FIFO_DEPTH, or a pop happens in the same cycle) -> char_in is written at wptr, wptr advances and wraps modulo FIFO_DEPTH.
- Full FIFO: char_valid=1 while full with no same-cycle pop -> byte dropped, overflow set on the next edge, level unchanged.
- Simultaneous push and pop: level unchanged and both pointers advance.
- FIFO is synchronous, with no fall-through. A byte pushed at edge N is visible to the FSM from cycle N+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If level!=0, pop the head into an 8-bit shift register, clear the divider, go to START. tx=0 from the next edge.
  - START: tx=0 for CLK_DIV cycles -> DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLK_DIV cycles, then shift right and increment the index. After bit 7 completes -> STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then, if level!=0, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length is 10*CLK_DIV cycles.
- Push-to-start-bit latency from an empty, idle state: char_valid at edge N gives tx falling at edge N+2.
- Divider: counts 0..CLK_DIV-1 and wraps. The bit transition occurs on the edge where the count equals CLK_DIV-1.
- busy = (state!=IDLE) | (level!=0), registered-equivalent: no combinational path from char_valid to busy.
- fifo_full = (level==FIFO_DEPTH).
- Pointer wrap: writes at index FIFO_DEPTH-1 wrap to index 0. level is kept as an explicit counter, so full and empty are unambiguous.

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP. tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles, and the frame becomes 11*CLK_DIV cycles.
- Undefined: no PARITY state, and frames are 8N1 at 10*CLK_DIV cycles.

Test Plan:
- Reset check: hold rstn=0, release -> tx=1, busy=0, level=0, overflow=0 with no activity for 100 cycles.
- Single byte 0x55, CLK_DIV=4 -> tx falls 2 cycles after the strobe. Line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 4 cycles. busy drops after 40 cycles.
- Burst of 3 bytes 0x41,0x42,0x43 on consecutive cycles -> level peaks at 2 or 3. Three back-to-back frames with no idle high between stop and the next start; byte order preserved.
- Overflow, FIFO_DEPTH=16, CLK_DIV=16: push 20 bytes 0x00..0x13 on consecutive cycles.
  - Required response: fifo_full asserts and overflow sets. Exactly 17 bytes are transmitted, 0x00..0x10 (one is popped during the burst); 0x11..0x13 are dropped.
- Reset mid-frame: assert rstn=0 during DATA bit 3 of 0xA5 -> tx=1 asynchronously and level=0. After release, a new byte 0x3C is transmitted cleanly.
- With UART_TX_PARITY_EN defined: byte 0x07 -> parity bit 1, frame of 11*CLK_DIV cycles. Byte 0x03 -> parity bit 0.
